// File: rtl/ldpc_layer_scheduler_pkg.sv
// Shared types and defaults for the layered LDPC decoder scheduler.
package ldpc_sched_pkg;

  localparam int unsigned NUM_LAYERS_DEF = 4;
  localparam int unsigned MAX_ITER_DEF   = 10;
  localparam int unsigned ITER_W         = 4;
  localparam int unsigned LAYER_W        = 2;

  // Each start pulse gets its own state, followed by a wait state for the matching done.
  // This keeps a done input from being accepted in the same cycle as its start pulse.
  typedef enum logic [3:0] {
    StIdle      = 4'd0,
    StLoad      = 4'd1,
    StLoadWait  = 4'd2,
    StLayer     = 4'd3,
    StLayerWait = 4'd4,
    StSynd      = 4'd5,
    StSyndWait  = 4'd6,
    StOut       = 4'd7,
    StOutWait   = 4'd8
  } sched_state_e;

  // A configured limit of zero selects the build-time default.
  function automatic logic [ITER_W-1:0] eff_limit(input logic [ITER_W-1:0] cfg,
                                                  input logic [ITER_W-1:0] dflt);
    return (cfg == '0) ? dflt : cfg;
  endfunction

endpackage

// File: rtl/ldpc_layer_scheduler_if.sv
// Frame handshake, core phase handshakes and status of the LDPC scheduler.
// The master modport is the scheduler side; the slave modport is the frame source plus core.
interface ldpc_layer_scheduler_if
  import ldpc_sched_pkg::*;
();

  logic               frame_valid;
  logic               frame_ready;
  logic [ITER_W-1:0]  cfg_max_iter;
  logic               abort;
  logic               load_start;
  logic               load_done;
  logic               layer_start;
  logic [LAYER_W-1:0] layer_idx;
  logic               layer_done;
  logic               synd_start;
  logic               synd_done;
  logic               synd_ok;
  logic               out_start;
  logic               out_done;
  logic               busy;
  logic               dec_done;
  logic               dec_success;
  logic [ITER_W-1:0]  iter_count;

  modport master (
    input  frame_valid, cfg_max_iter, abort, load_done, layer_done, synd_done, synd_ok,
           out_done,
    output frame_ready, load_start, layer_start, layer_idx, synd_start, out_start, busy,
           dec_done, dec_success, iter_count
  );

  modport slave (
    output frame_valid, cfg_max_iter, abort, load_done, layer_done, synd_done, synd_ok,
           out_done,
    input  frame_ready, load_start, layer_start, layer_idx, synd_start, out_start, busy,
           dec_done, dec_success, iter_count
  );

endinterface

// File: rtl/ldpc_layer_scheduler.sv
// Phase sequencer for the layered min-sum LDPC decoder core: load, per-layer update,
// syndrome check and output, with layer/iteration counting and frame status.
// Build option: define LDPC_SCHED_EARLY_TERM_EN to stop after the first iteration whose
// syndrome is all-zero; otherwise every frame runs exactly its iteration limit.
module ldpc_layer_scheduler
  import ldpc_sched_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int unsigned MAX_ITER   = MAX_ITER_DEF
) (
  input logic                    clk,
  input logic                    rst,
  ldpc_layer_scheduler_if.master bus
);

  localparam logic [LAYER_W-1:0] LastLayer = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [ITER_W-1:0]  DefLimit  = ITER_W'(MAX_ITER);

  sched_state_e       state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [ITER_W-1:0]  iter_q, iter_d;
  logic [ITER_W-1:0]  limit_q, limit_d;
  logic               success_q, success_d;
  logic               done_q, done_d;

  logic aborting;
  logic stop_iter;

  // Abort only has an effect once a frame has been accepted.
  assign aborting = bus.abort && (state_q != StIdle);

`ifdef LDPC_SCHED_EARLY_TERM_EN
  assign stop_iter = bus.synd_ok || (iter_q == limit_q);
`else
  assign stop_iter = (iter_q == limit_q);
`endif

  // State, counters and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      layer_q   <= '0;
      iter_q    <= '0;
      limit_q   <= DefLimit;
      success_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      iter_q    <= iter_d;
      limit_q   <= limit_d;
      success_q <= success_d;
      done_q    <= done_d;
    end
  end

  // Next-state: one pulse state per phase, then wait for the matching done.
  always_comb begin
    state_d = state_q;
    if (aborting) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:      if (bus.frame_valid) state_d = StLoad;
        StLoad:      state_d = StLoadWait;
        StLoadWait:  if (bus.load_done) state_d = StLayer;
        StLayer:     state_d = StLayerWait;
        StLayerWait: begin
          if (bus.layer_done) state_d = (layer_q == LastLayer) ? StSynd : StLayer;
        end
        StSynd:      state_d = StSyndWait;
        StSyndWait:  if (bus.synd_done) state_d = stop_iter ? StOut : StLayer;
        StOut:       state_d = StOutWait;
        StOutWait:   if (bus.out_done) state_d = StIdle;
        default:     state_d = StIdle;
      endcase
    end
  end

  // Counter and status updates tied to frame acceptance and the done handshakes.
  always_comb begin
    layer_d   = layer_q;
    iter_d    = iter_q;
    limit_d   = limit_q;
    success_d = success_q;
    done_d    = 1'b0;
    if (aborting) begin
      // Iteration count is held so the partial progress stays visible.
      layer_d   = '0;
      success_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.frame_valid) begin
            limit_d   = eff_limit(bus.cfg_max_iter, DefLimit);
            iter_d    = '0;
            layer_d   = '0;
            success_d = 1'b0;
          end
        end
        StLayerWait: begin
          if (bus.layer_done) begin
            if (layer_q == LastLayer) begin
              layer_d = '0;
              if (iter_q < limit_q) iter_d = iter_q + 1'b1;
            end else begin
              layer_d = layer_q + 1'b1;
            end
          end
        end
        StSyndWait: if (bus.synd_done) success_d = bus.synd_ok;
        StOutWait:  if (bus.out_done) done_d = 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs: start pulses decode directly from the pulse states.
  always_comb begin
    bus.frame_ready = (state_q == StIdle);
    bus.busy        = (state_q != StIdle);
    bus.load_start  = (state_q == StLoad);
    bus.layer_start = (state_q == StLayer);
    bus.synd_start  = (state_q == StSynd);
    bus.out_start   = (state_q == StOut);
    bus.layer_idx   = layer_q;
    bus.iter_count  = iter_q;
    bus.dec_done    = done_q;
    bus.dec_success = success_q;
  end

endmodule

// File: tb/tb_ldpc_layer_scheduler.sv
// Directed plus randomized bench for ldpc_layer_scheduler with a frame-level reference model.
module tb_ldpc_layer_scheduler;
  import ldpc_sched_pkg::*;

  localparam int NL = 4;
  localparam int MI = 10;

  localparam int W_LOAD  = 0;
  localparam int W_LAYER = 1;
  localparam int W_SYND  = 2;
  localparam int W_OUT   = 3;
  localparam int W_DEC   = 4;

  logic clk;
  logic rst;

  ldpc_layer_scheduler_if bus ();

  ldpc_layer_scheduler #(
    .NUM_LAYERS(NL),
    .MAX_ITER  (MI)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int n_layer = 0;
  int n_synd  = 0;
  int n_dec   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.layer_start === 1'b1) n_layer++;
    if (bus.synd_start === 1'b1) n_synd++;
    if (bus.dec_done === 1'b1) n_dec++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: iterations run and final success from the syndrome pattern.
  function automatic void model(input logic [3:0] cfg, input logic [15:0] pat,
                                output int iters, output logic succ);
    int lim;
    lim = (cfg == 4'd0) ? MI : int'(cfg);
    iters = lim;
`ifdef LDPC_SCHED_EARLY_TERM_EN
    for (int k = 1; k <= lim; k++) begin
      if (pat[k-1]) begin
        iters = k;
        break;
      end
    end
`endif
    succ = pat[iters-1];
  endfunction

  function automatic logic get_sig(input int which);
    case (which)
      W_LOAD:  return bus.load_start;
      W_LAYER: return bus.layer_start;
      W_SYND:  return bus.synd_start;
      W_OUT:   return bus.out_start;
      default: return bus.dec_done;
    endcase
  endfunction

  // Returns at the negedge where the signal is high; checks the current cycle first.
  task automatic wait_start(input int which);
    int n;
    n = 0;
    while (get_sig(which) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (get_sig(which) !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL wait_%0d: observed timeout expected pulse", which);
    end
  endtask

  task automatic set_done(input int which, input logic v, input logic ok);
    case (which)
      W_LOAD:  bus.load_done = v;
      W_LAYER: bus.layer_done = v;
      W_SYND:  begin bus.synd_done = v; bus.synd_ok = ok; end
      default: bus.out_done = v;
    endcase
  endtask

  // Core response: done one cycle long, at least one cycle after the start pulse.
  task automatic respond(input int which, input logic ok);
    repeat ($urandom_range(1, 3)) @(negedge clk);
    set_done(which, 1'b1, ok);
    @(negedge clk);
    set_done(which, 1'b0, 1'b0);
  endtask

  task automatic start_frame(input logic [3:0] cfg);
    check("frame_ready_idle", bus.frame_ready, 1'b1);
    bus.frame_valid  = 1'b1;
    bus.cfg_max_iter = cfg;
    @(negedge clk);
    bus.frame_valid  = 1'b0;
    bus.cfg_max_iter = $urandom_range(0, 15);
    check("busy_after_accept", bus.busy, 1'b1);
  endtask

  task automatic do_load(input logic early_done);
    wait_start(W_LOAD);
    if (early_done) begin
      bus.load_done = 1'b1;
      @(negedge clk);
      bus.load_done = 1'b0;
      check("early_load_done_ignored", bus.layer_start, 1'b0);
    end
    respond(W_LOAD, 1'b0);
  endtask

  task automatic do_iter(input logic ok);
    for (int l = 0; l < NL; l++) begin
      wait_start(W_LAYER);
      check("layer_idx", 32'(bus.layer_idx), l);
      respond(W_LAYER, 1'b0);
    end
    wait_start(W_SYND);
    respond(W_SYND, ok);
  endtask

  task automatic finish_frame(input int eit, input logic esucc,
                              input int nl0, input int ns0, input int nd0);
    wait_start(W_OUT);
    respond(W_OUT, 1'b0);
    wait_start(W_DEC);
    check("dec_success", bus.dec_success, esucc);
    check("iter_count", 32'(bus.iter_count), eit);
    check("ready_at_done", bus.frame_ready, 1'b1);
    @(negedge clk);
    check("dec_done_width", bus.dec_done, 1'b0);
    check("layer_pulses", n_layer - nl0, eit * NL);
    check("synd_pulses", n_synd - ns0, eit);
    check("dec_done_pulses", n_dec - nd0, 1);
  endtask

  task automatic run_frame(input logic [3:0] cfg, input logic [15:0] pat, input logic early);
    int eit;
    logic esucc;
    int nl0, ns0, nd0;
    model(cfg, pat, eit, esucc);
    nl0 = n_layer;
    ns0 = n_synd;
    nd0 = n_dec;
    start_frame(cfg);
    do_load(early);
    for (int it = 1; it <= eit; it++) do_iter(pat[it-1]);
    finish_frame(eit, esucc, nl0, ns0, nd0);
  endtask

  initial begin
    int nl0, ns0, nd0, eit;
    logic esucc;

    rst = 1'b1;
    bus.frame_valid = 1'b0;
    bus.cfg_max_iter = '0;
    bus.abort = 1'b0;
    bus.load_done = 1'b0;
    bus.layer_done = 1'b0;
    bus.synd_done = 1'b0;
    bus.synd_ok = 1'b0;
    bus.out_done = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_frame_ready", bus.frame_ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_pulses", {bus.load_start, bus.layer_start, bus.synd_start, bus.out_start}, 4'b0);
    check("rst_dec_done", bus.dec_done, 1'b0);
    check("rst_dec_success", bus.dec_success, 1'b0);
    check("rst_iter_count", 32'(bus.iter_count), 0);
    check("rst_layer_idx", 32'(bus.layer_idx), 0);
    rst = 1'b0;
    @(negedge clk);

    // Syndrome clean on the first check; also a premature load_done.
    run_frame(4'd0, 16'h0001, 1'b1);
    // Never clean, default limit.
    run_frame(4'd0, 16'h0000, 1'b0);
    // Limit 3, clean from the second check onward.
    run_frame(4'd3, 16'h0006, 1'b0);

    // Abort in the layer-2 wait of the second iteration.
    nd0 = n_dec;
    start_frame(4'd3);
    do_load(1'b0);
    do_iter(1'b0);
    for (int l = 0; l < 2; l++) begin
      wait_start(W_LAYER);
      respond(W_LAYER, 1'b0);
    end
    wait_start(W_LAYER);
    check("abort_layer_idx", 32'(bus.layer_idx), 2);
    @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_ready", bus.frame_ready, 1'b1);
    check("abort_success", bus.dec_success, 1'b0);
    check("abort_iter_held", 32'(bus.iter_count), 1);
    nl0 = n_layer;
    repeat (5) @(negedge clk);
    check("abort_no_dec_done", n_dec - nd0, 0);
    check("abort_no_layer", n_layer - nl0, 0);

    // Abort together with frame_valid in idle: frame still accepted.
    bus.abort = 1'b1;
    start_frame(4'd1);
    bus.abort = 1'b0;
    check("abort_idle_accept", bus.load_start, 1'b1);
    nl0 = n_layer; ns0 = n_synd; nd0 = n_dec;
    do_load(1'b0);
    do_iter(1'b1);
    finish_frame(1, 1'b1, nl0 - 0, ns0, nd0);

    // layer_done held high and a stray synd_done during a layer wait.
    nl0 = n_layer; ns0 = n_synd; nd0 = n_dec;
    start_frame(4'd1);
    do_load(1'b0);
    bus.layer_done = 1'b1;
    for (int l = 0; l < NL; l++) begin
      wait_start(W_LAYER);
      check("held_layer_idx", 32'(bus.layer_idx), l);
      @(negedge clk);
      if (l == 0) begin
        bus.synd_done = 1'b1;
        bus.synd_ok = 1'b0;
        @(negedge clk);
        bus.synd_done = 1'b0;
      end
    end
    wait_start(W_SYND);
    bus.layer_done = 1'b0;
    respond(W_SYND, 1'b1);
    finish_frame(1, 1'b1, nl0, ns0, nd0);

    // Reset while waiting for the syndrome, then a normal frame.
    start_frame(4'd0);
    do_load(1'b0);
    do_iter(1'b0);
    for (int l = 0; l < NL; l++) begin
      wait_start(W_LAYER);
      respond(W_LAYER, 1'b0);
    end
    wait_start(W_SYND);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_ready", bus.frame_ready, 1'b1);
    check("rst_mid_iter", 32'(bus.iter_count), 0);
    check("rst_mid_success", bus.dec_success, 1'b0);
    run_frame(4'd2, 16'h0002, 1'b0);

    // Randomized frames against the model.
    for (int f = 0; f < 6; f++) begin
      run_frame(4'($urandom_range(0, 5)), 16'($urandom), 1'b0);
    end

    // Frame request while busy is not queued.
    model(4'd1, 16'h0000, eit, esucc);
    nl0 = n_layer; ns0 = n_synd; nd0 = n_dec;
    start_frame(4'd1);
    bus.frame_valid = 1'b1;
    do_load(1'b0);
    do_iter(1'b0);
    bus.frame_valid = 1'b0;
    finish_frame(eit, esucc, nl0, ns0, nd0);
    repeat (3) @(negedge clk);
    check("busy_frame_not_queued", bus.busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
